// File: rtl/sobel_pkg.sv
// sobel_pkg: shared frame defaults, sequencer state encoding and 3x3 tap offsets.
package sobel_pkg;

    localparam int DEF_H_RES = 512;
    localparam int DEF_V_RES = 384;
    localparam int DEF_PIX_W = 8;

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, PRESENT, DONE} state_t;

    // taps a..i in raster order: k%3 selects the column, k/3 the row
    localparam int TAP_DX [9] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};
    localparam int TAP_DY [9] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};

endpackage

// File: rtl/sobel_window_sequencer_if.sv
// sobel_window_sequencer_if: frame-buffer read port plus window hand-off to the Sobel datapath.
interface sobel_window_sequencer_if
    import sobel_pkg::*;
#(
    parameter int PIX_W  = DEF_PIX_W,
    parameter int ADDR_W = 18
);
    logic                 mem_rd_en;
    logic [ADDR_W-1:0]    mem_addr;
    logic [PIX_W-1:0]     mem_rd_data;
    logic                 win_valid;
    logic                 win_ready;
    logic [9*PIX_W-1:0]   win_data;
    logic [10:0]          win_x;
    logic [10:0]          win_y;
    logic [ADDR_W-1:0]    win_addr;

    modport master (
        output mem_rd_en, mem_addr, win_valid, win_data, win_x, win_y, win_addr,
        input  mem_rd_data, win_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr, win_valid, win_data, win_x, win_y, win_addr,
        output mem_rd_data, win_ready
    );

endinterface

// File: rtl/tap_address_gen.sv
// tap_address_gen: maps centre (x,y) and tap index k to a frame-buffer address and an in-frame flag.
module tap_address_gen
    import sobel_pkg::*;
#(
    parameter int H_RES  = DEF_H_RES,
    parameter int V_RES  = DEF_V_RES,
    parameter int ADDR_W = 18
) (
    input  logic [10:0]       i_x,
    input  logic [10:0]       i_y,
    input  logic [3:0]        i_k,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_in_bounds
);
    int          w_dx;
    int          w_dy;
    logic        w_x_ok;
    logic        w_y_ok;
    logic [10:0] w_tx;
    logic [10:0] w_ty;

    always_comb begin
        w_dx        = TAP_DX[i_k];
        w_dy        = TAP_DY[i_k];
        // edges are tested before any subtraction so a -1 offset never wraps
        w_x_ok      = (w_dx < 0) ? (i_x != 11'd0) : (int'(i_x) + w_dx < H_RES);
        w_y_ok      = (w_dy < 0) ? (i_y != 11'd0) : (int'(i_y) + w_dy < V_RES);
        w_tx        = !w_x_ok ? 11'd0 : (w_dx < 0) ? i_x - 11'd1 : i_x + 11'(w_dx);
        w_ty        = !w_y_ok ? 11'd0 : (w_dy < 0) ? i_y - 11'd1 : i_y + 11'(w_dy);
        o_in_bounds = w_x_ok && w_y_ok;
        o_addr      = o_in_bounds ? ADDR_W'(w_tx) + ADDR_W'(w_ty) * ADDR_W'(H_RES) : '0;
    end

endmodule

// File: rtl/sobel_window_sequencer.sv
// sobel_window_sequencer: raster-scans the frame buffer and presents zero-padded 3x3 windows.
module sobel_window_sequencer
    import sobel_pkg::*;
#(
    parameter int H_RES  = DEF_H_RES,
    parameter int V_RES  = DEF_V_RES,
    parameter int PIX_W  = DEF_PIX_W,
    parameter int ADDR_W = 18,
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_start,
    input  logic i_abort,
    output logic o_busy,
    output logic o_done,
    sobel_window_sequencer_if.master bus
);
    state_t             r_state;
    logic [3:0]         r_k;
    logic [10:0]        r_x;
    logic [10:0]        r_y;
    logic [1:0]         r_drain;
    logic [5:0]         r_pipe [RD_LAT];
    logic [9*PIX_W-1:0] r_win;
    logic               w_fetch;
    logic               w_clear;
    logic               w_last;
    logic               w_in_bounds;
    logic [ADDR_W-1:0]  w_tap_addr;
    logic [5:0]         w_tail;

    tap_address_gen #(.H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W)) u_tap (
        .i_x         (r_x),
        .i_y         (r_y),
        .i_k         (r_k),
        .o_addr      (w_tap_addr),
        .o_in_bounds (w_in_bounds)
    );

    always_comb begin
        w_fetch = r_state == FETCH;
        w_clear = r_state != IDLE && (i_abort || r_state == DONE);
        w_last  = r_x == 11'(H_RES - 1) && r_y == 11'(V_RES - 1);
        w_tail  = r_pipe[RD_LAT-1];
    end

    assign bus.mem_rd_en = w_fetch && w_in_bounds;
    assign bus.mem_addr  = bus.mem_rd_en ? w_tap_addr : '0;
    assign bus.win_valid = r_state == PRESENT;
    assign bus.win_data  = r_win;
    assign bus.win_x     = r_x;
    assign bus.win_y     = r_y;
    assign bus.win_addr  = ADDR_W'(r_x) + ADDR_W'(r_y) * ADDR_W'(H_RES);
    assign o_busy        = r_state != IDLE;
    assign o_done        = r_state == DONE;

    // pipeline stage = {valid, zero fill, tap index}; the tail lines up with mem_rd_data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_drain <= '0;
            r_win   <= '0;
            for (int i = 0; i < RD_LAT; i++) r_pipe[i] <= '0;
        end else if (w_clear) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_drain <= '0;
            r_win   <= '0;
            for (int i = 0; i < RD_LAT; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= {w_fetch, !w_in_bounds, r_k};
            for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
            if (w_tail[5]) r_win[int'(w_tail[3:0])*PIX_W +: PIX_W] <= w_tail[4] ? '0 : bus.mem_rd_data;
            case (r_state)
                IDLE: r_state <= (i_start && !i_abort) ? FETCH : IDLE;
                FETCH: begin
                    r_k     <= (r_k == 4'd8) ? 4'd0 : r_k + 4'd1;
                    r_state <= (r_k == 4'd8) ? DRAIN : FETCH;
                end
                DRAIN: begin
                    r_drain <= (r_drain == 2'(RD_LAT - 1)) ? 2'd0 : r_drain + 2'd1;
                    r_state <= (r_drain == 2'(RD_LAT - 1)) ? PRESENT : DRAIN;
                end
                PRESENT: if (bus.win_ready) begin
                    r_state <= w_last ? DONE : FETCH;
                    if (!w_last) begin
                        r_x <= (r_x == 11'(H_RES - 1)) ? 11'd0 : r_x + 11'd1;
                        r_y <= (r_x == 11'(H_RES - 1)) ? r_y + 11'd1 : r_y;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_window_sequencer.sv
// tb_sobel_window_sequencer: scoreboard bench for a full-size RD_LAT=1 instance and a small RD_LAT=3 instance.
module tb_sobel_window_sequencer;

    typedef struct {
        logic [71:0] d;
        int          x;
        int          y;
        int          a;
    } win_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a_start = 1'b0, a_abort = 1'b0, a_ready = 1'b0, a_busy, a_done;
    logic b_start = 1'b0, b_abort = 1'b0, b_ready = 1'b0, b_busy, b_done;
    logic [7:0]  a_rd_q;
    logic [7:0]  b_pipe [3];
    logic [71:0] b_last = '0;
    logic [71:0] d_hold;
    int n_checks = 0, n_errors = 0;
    int b_hs = 0, b_done_cnt = 0;
    int a_rdq[$], b_rdq[$];
    win_t a_wq[$], b_wq[$];
    win_t a_e, b_e;

    always #5 clk = ~clk;

    sobel_window_sequencer_if #(.PIX_W(8), .ADDR_W(18)) a_if ();
    sobel_window_sequencer_if #(.PIX_W(8), .ADDR_W(8))  b_if ();

    sobel_window_sequencer #(.H_RES(512), .V_RES(384), .PIX_W(8), .ADDR_W(18), .RD_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_start(a_start), .i_abort(a_abort),
        .o_busy(a_busy), .o_done(a_done), .bus(a_if)
    );

    sobel_window_sequencer #(.H_RES(16), .V_RES(12), .PIX_W(8), .ADDR_W(8), .RD_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_start(b_start), .i_abort(b_abort),
        .o_busy(b_busy), .o_done(b_done), .bus(b_if)
    );

    // RAM models: data = addr[7:0] + 1, delivered RD_LAT cycles after the read
    always @(posedge clk) a_rd_q <= a_if.mem_addr[7:0] + 8'd1;
    always @(posedge clk) begin
        b_pipe[0] <= b_if.mem_addr[7:0] + 8'd1;
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
    end
    assign a_if.mem_rd_data = a_rd_q;
    assign b_if.mem_rd_data = b_pipe[2];
    assign a_if.win_ready   = a_ready;
    assign b_if.win_ready   = b_ready;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] model_win(input int h, input int v, input int x, input int y);
        logic [71:0] d;
        int tx, ty;
        d = '0;
        for (int k = 0; k < 9; k++) begin
            tx = x + k % 3 - 1;
            ty = y + k / 3 - 1;
            if (tx >= 0 && tx < h && ty >= 0 && ty < v) d[k*8 +: 8] = 8'((tx + ty * h) % 256 + 1);
        end
        return d;
    endfunction

    function automatic win_t none_win();
        win_t e;
        e.d = '1;
        e.x = -1;
        e.y = -1;
        e.a = -1;
        return e;
    endfunction

    task automatic push_pixel(input bit sel, input int x, input int y, input int ntaps, input bit win);
        int h, v, tx, ty;
        win_t e;
        h = sel ? 16 : 512;
        v = sel ? 12 : 384;
        for (int k = 0; k < ntaps; k++) begin
            tx = x + k % 3 - 1;
            ty = y + k / 3 - 1;
            if (tx >= 0 && tx < h && ty >= 0 && ty < v) begin
                if (sel) b_rdq.push_back(tx + ty * h);
                else     a_rdq.push_back(tx + ty * h);
            end
        end
        if (win) begin
            e.d = model_win(h, v, x, y);
            e.x = x;
            e.y = y;
            e.a = x + y * h;
            if (sel) b_wq.push_back(e);
            else     a_wq.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (a_if.mem_rd_en)
            check("a_rd_addr", 72'(a_if.mem_addr), a_rdq.size() > 0 ? 72'(a_rdq.pop_front()) : '1);
        if (a_if.win_valid && a_if.win_ready) begin
            a_e = a_wq.size() > 0 ? a_wq.pop_front() : none_win();
            check("a_win_data", a_if.win_data, a_e.d);
            check("a_win_x", 72'(a_if.win_x), 72'(a_e.x));
            check("a_win_y", 72'(a_if.win_y), 72'(a_e.y));
            check("a_win_addr", 72'(a_if.win_addr), 72'(a_e.a));
        end
    end

    always @(negedge clk) begin
        if (b_if.mem_rd_en)
            check("b_rd_addr", 72'(b_if.mem_addr), b_rdq.size() > 0 ? 72'(b_rdq.pop_front()) : '1);
        if (b_if.win_valid && b_if.win_ready) begin
            b_e = b_wq.size() > 0 ? b_wq.pop_front() : none_win();
            check("b_win_data", b_if.win_data, b_e.d);
            check("b_win_x", 72'(b_if.win_x), 72'(b_e.x));
            check("b_win_y", 72'(b_if.win_y), 72'(b_e.y));
            check("b_win_addr", 72'(b_if.win_addr), 72'(b_e.a));
            b_hs++;
            b_last = b_if.win_data;
        end
        if (b_done) b_done_cnt++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input bit sel, input int lim, output int n);
        n = 0;
        while (!(sel ? b_if.win_valid : a_if.win_valid) && n < lim) begin
            cyc();
            n++;
        end
    endtask

    task automatic wait_xy(input bit sel, input int x, input int y, input int lim, input string tag);
        int n;
        n = 0;
        while (!((sel ? b_if.win_x : a_if.win_x) == 11'(x) && (sel ? b_if.win_y : a_if.win_y) == 11'(y)) && n < lim) begin
            cyc();
            n++;
        end
        check(tag, 72'(n < lim), 72'(1));
    endtask

    initial begin
        int n, nv, nr;
        repeat (3) cyc();
        check("rst_a_ctrl", 72'({a_busy, a_done, a_if.win_valid, a_if.mem_rd_en, a_if.win_x, a_if.win_y}), 72'(0));
        check("rst_a_data", a_if.win_data, 72'(0));
        check("rst_a_addr", 72'({a_if.win_addr, a_if.mem_addr}), 72'(0));
        rst_n = 1'b1;
        a_ready = 1'b1;
        b_ready = 1'b1;
        cyc();

        // instance A: row 0 through (1,1), backpressure at (3,0)
        for (int i = 0; i < 513; i++) push_pixel(1'b0, i % 512, i / 512, 9, 1'b1);
        push_pixel(1'b0, 1, 1, 9, 1'b0);
        a_start = 1'b1;
        cyc();
        a_start = 1'b0;
        check("a_busy_fetch", 72'(a_busy), 72'(1));
        wait_valid(1'b0, 50, n);
        check("a_lat_00", 72'(n), 72'(10));
        check("a_data_00", a_if.win_data, 72'h020100020100000000);
        check("a_addr_00", 72'(a_if.win_addr), 72'(0));
        wait_xy(1'b0, 3, 0, 200, "a_reach_30");
        a_ready = 1'b0;
        wait_valid(1'b0, 50, n);
        check("a_lat_30", 72'(n), 72'(10));
        d_hold = a_if.win_data;
        repeat (5) begin
            check("a_bp_valid", 72'(a_if.win_valid), 72'(1));
            check("a_bp_data", a_if.win_data, d_hold);
            check("a_bp_rd_en", 72'(a_if.mem_rd_en), 72'(0));
            check("a_bp_x", 72'(a_if.win_x), 72'(3));
            cyc();
        end
        check("a_bp_hold_x", 72'(a_if.win_x), 72'(3));
        a_ready = 1'b1;
        cyc();
        check("a_bp_adv_x", 72'(a_if.win_x), 72'(4));
        wait_xy(1'b0, 1, 1, 8000, "a_reach_11");
        a_ready = 1'b0;
        wait_valid(1'b0, 50, n);
        check("a_data_11", a_if.win_data, 72'h030201030201030201);
        check("a_addr_11", 72'(a_if.win_addr), 72'(513));
        a_abort = 1'b1;
        cyc();
        a_abort = 1'b0;
        check("a_abort_idle", 72'({a_busy, a_if.win_valid, a_done}), 72'(0));
        check("a_rdq_drained", 72'(a_rdq.size()), 72'(0));
        check("a_wq_drained", 72'(a_wq.size()), 72'(0));

        // instance B: full 16x12 frame with RD_LAT=3
        for (int i = 0; i < 192; i++) push_pixel(1'b1, i % 16, i / 16, 9, 1'b1);
        b_hs = 0;
        b_done_cnt = 0;
        b_start = 1'b1;
        cyc();
        b_start = 1'b0;
        n = 1;
        while (b_busy && n < 5000) begin
            n++;
            cyc();
        end
        check("b_total_cycles", 72'(n), 72'(192 * 13 + 2));
        check("b_handshakes", 72'(b_hs), 72'(192));
        check("b_done_pulses", 72'(b_done_cnt), 72'(1));
        check("b_last_zero_taps", 72'({b_last[23:16], b_last[47:40], b_last[71:48]}), 72'(0));
        check("b_idle_after_done", 72'({b_if.win_x, b_if.win_y, b_if.win_valid}), 72'(0));
        check("b_rdq_drained", 72'(b_rdq.size()), 72'(0));
        check("b_wq_drained", 72'(b_wq.size()), 72'(0));

        // instance B: abort at tap 4 of (10,10)
        for (int i = 0; i < 170; i++) push_pixel(1'b1, i % 16, i / 16, 9, 1'b1);
        push_pixel(1'b1, 10, 10, 5, 1'b0);
        b_done_cnt = 0;
        b_start = 1'b1;
        cyc();
        b_start = 1'b0;
        wait_xy(1'b1, 10, 10, 3000, "b_reach_1010");
        repeat (4) cyc();
        b_abort = 1'b1;
        cyc();
        b_abort = 1'b0;
        check("b_abort_idle", 72'({b_busy, b_if.win_valid, b_done}), 72'(0));
        check("b_abort_clear", 72'({b_if.win_x, b_if.win_y, b_if.win_addr}), 72'(0));
        check("b_abort_data", b_if.win_data, 72'(0));
        nv = 0;
        nr = 0;
        repeat (30) begin
            if (b_if.win_valid) nv++;
            if (b_if.mem_rd_en) nr++;
            cyc();
        end
        check("b_post_abort_valid", 72'(nv), 72'(0));
        check("b_post_abort_reads", 72'(nr), 72'(0));
        check("b_post_abort_done", 72'(b_done_cnt), 72'(0));
        check("b_abort_rdq_drained", 72'(b_rdq.size()), 72'(0));
        check("b_abort_wq_drained", 72'(b_wq.size()), 72'(0));

        b_start = 1'b1;
        b_abort = 1'b1;
        cyc();
        b_start = 1'b0;
        b_abort = 1'b0;
        check("b_abort_beats_start", 72'(b_busy), 72'(0));

        // instance B: restart from (0,0)
        b_ready = 1'b0;
        push_pixel(1'b1, 0, 0, 9, 1'b0);
        b_start = 1'b1;
        cyc();
        b_start = 1'b0;
        wait_valid(1'b1, 50, n);
        check("b_lat_restart", 72'(n), 72'(12));
        check("b_restart_xy", 72'({b_if.win_x, b_if.win_y}), 72'(0));
        check("b_restart_data", b_if.win_data, model_win(16, 12, 0, 0));
        b_abort = 1'b1;
        cyc();
        b_abort = 1'b0;
        check("b_restart_rdq_drained", 72'(b_rdq.size()), 72'(0));

        // asynchronous reset in the middle of a fetch
        a_ready = 1'b1;
        a_start = 1'b1;
        cyc();
        a_start = 1'b0;
        cyc();
        cyc();
        check("a_busy_pre_rst", 72'(a_busy), 72'(1));
        rst_n = 1'b0;
        #1;
        check("rst_mid_ctrl", 72'({a_busy, a_done, a_if.win_valid, a_if.mem_rd_en, a_if.win_x, a_if.win_y}), 72'(0));
        check("rst_mid_data", a_if.win_data, 72'(0));
        check("rst_mid_addr", 72'({a_if.win_addr, a_if.mem_addr}), 72'(0));
        cyc();
        rst_n = 1'b1;
        cyc();
        check("rst_rdq_empty", 72'(a_rdq.size()), 72'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sobel_window_sequencer.md
Name: sobel_window_sequencer

Overview:
- Raster-scans a H_RES x V_RES single-port frame-buffer RAM in x-major order, row by row.
- For each centre pixel it fetches the 3x3 neighbourhood, taps a,b,c / d,e,f / g,h,i as k=0..8. Each tap is read as one RAM access per cycle.
- Taps that fall outside the frame are zero-padded internally; no RAM access is issued for them.
- The 9-pixel window is handed to the Sobel datapath over a valid/ready handshake, together with the centre coordinate and its RAM address for write-back.

Parameters:
- H_RES, 512, frame width in pixels.
- V_RES, 384, frame height in pixels.
- PIX_W, 8, pixel width in bits.
- ADDR_W, 18, RAM address width; must satisfy 2^ADDR_W >= H_RES*V_RES.
- RD_LAT, 1, RAM read latency in cycles; legal values are 1..3.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; starts a frame scan when idle.
- abort  in  1  synchronous; cancels the scan.
- mem_rd_en  out  1  RAM read strobe.
- mem_addr  out  ADDR_W  RAM read address.
- mem_rd_data  in  PIX_W  RAM data, valid RD_LAT cycles after mem_rd_en.
- win_valid  out  1  window available.
- win_ready  in  1  consumer accepts the window.
- win_data  out  9*PIX_W  tap k at bits [k*PIX_W +: PIX_W].
- win_x  out  11  centre x coordinate.
- win_y  out  11  centre y coordinate.
- win_addr  out  ADDR_W  centre address, x + y*H_RES.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last window is accepted.

Behaviour:
- Reset, and also IDLE entry: all outputs are 0, including win_data, x, y, tap counter and read pipeline.
- States:
  - IDLE: on start, x=y=0 and go to FETCH. start is ignored in every other state.
  - FETCH: tap counter k runs 0..8, one tap per cycle. Tap k uses offsets dx = k%3 - 1 and dy = k/3 - 1.
    - In-bounds tap (0 <= x+dx < H_RES and 0 <= y+dy < V_RES): mem_rd_en=1 and mem_addr = (x+dx) + (y+dy)*H_RES.
    - Out-of-bounds tap: mem_rd_en=0, mem_addr=0, and the tap is marked for zero fill.
    - Each tap's index and zero flag travel down an RD_LAT-deep shift pipeline. When a tap arrives, win_data[k] gets mem_rd_data, or 0 if it is flagged.
    - After k=8 is issued, go to DRAIN.
  - DRAIN: wait RD_LAT cycles for the pipeline to empty, then go to PRESENT.
  - PRESENT: win_valid=1. win_data, win_x, win_y and win_addr stay stable until win_valid && win_ready.
    - On that handshake, if (x,y) = (H_RES-1, V_RES-1), go to DONE.
    - Otherwise advance: x wraps from H_RES-1 to 0 with y+1, else x+1. Then go to FETCH.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- Latency and throughput:
  - First mem_rd_en (or first zero tap) occurs in the cycle after start.
  - win_valid rises 9+RD_LAT cycles after FETCH is entered.
  - Each pixel takes 9+RD_LAT+1 cycles when win_ready is held high.
- Arithmetic:
  - Coordinates are unsigned 11 bits; the boundary compare is done before subtracting, so coordinates never underflow.
  - The address product is computed at ADDR_W bits with no truncation.
- abort: from any non-IDLE state, go to IDLE next cycle. The read pipeline is flushed and in-flight data is discarded. done is not pulsed and win_valid drops.
- abort and start in the same cycle: abort wins.
- Async reset mid-frame: immediate return to the reset state.
- mem_rd_en is never asserted outside FETCH.

Decomposition:
- Package sobel_pkg holds:
  - H_RES, V_RES, PIX_W defaults;
  - state enum state_t {IDLE, FETCH, DRAIN, PRESENT, DONE};
  - tap offset constants TAP_DX[9] and TAP_DY[9].
- Sub-module tap_address_gen: a combinational block mapping (x, y, k) to {addr, in_bounds}. It is instantiated once and shared across taps by k.

Test Plan:
- Memory model for all cases: mem_rd_data = addr[7:0] + 1, so zero pads are distinguishable from RAM data.
- Reset: assert rst_n=0 mid-FETCH -> all outputs 0 immediately; busy=0.
- Pixel (0,0), RD_LAT=1:
  - start -> exactly 4 reads, at addresses 0, 1, 512, 513.
  - Resulting win_data taps 0..8 = {0,0,0,0,1,2,0,1,2}; win_addr=0.
  - win_valid appears 10 cycles after FETCH entry.
- Pixel (1,1), interior:
  - Reads at addresses 0, 1, 2, 512, 513, 514, 1024, 1025, 1026.
  - win_data = {1,2,3,1,2,3,1,2,3}; win_addr=513.
- Backpressure: win_ready=0 for 5 cycles at pixel (3,0) -> win_valid and win_data are stable throughout; no mem_rd_en; x advances only after the handshake.
- Frame end: full scan with win_ready=1 -> exactly 196608 handshakes.
  - Last window is (511,383) with taps 2, 5, 6, 7, 8 zero.
  - done pulses one cycle; busy falls.
  - Total cycles = 196608*11 + 2.
- Abort plus RD_LAT=3:
  - abort at tap k=4 of pixel (10,10) -> IDLE next cycle; no win_valid; no done.
  - A new start then restarts at (0,0), with win_valid 12 cycles after FETCH entry.
